ahb_slave_if: RTL and testbench
===============================

Name: ahb_slave_if

Overview:
- AHB-side slave interface of the AHB-to-APB bridge; sits directly downstream of the AHB master.
- Decodes the address into one of three peripheral regions and inserts wait states until the APB side completes.
- Returns read data, or a two-cycle ERROR response for unmapped addresses.
- Pipelines address, data and direction for the APB controller.

Parameters:
BASE_ADDR, 32'h8000_0000, base of the bridge's address space
REGION_BITS, 26, log2 of the region size (64 MB per region)
TIMEOUT_CYCLES, 16, cycles to wait for apb_done before erroring (only with TIMEOUT_EN)

Ports:
hclk  in  1  bus clock; all state changes on rising edge
hreset  in  1  asynchronous active-high reset
hwrite  in  1  transfer direction from master (1 = write)
hreadyin  in  1  bus-ready input from master side
htrans  in  2  0 IDLE, 1 BUSY, 2 NONSEQ, 3 SEQ
haddr  in  32  address-phase address
hwdata  in  32  data-phase write data
prdata  in  32  read data from APB controller
apb_done  in  1  one-cycle pulse: APB transfer finished
hr_readyout  out  1  registered HREADY to master
hresp  out  2  registered response: 00 OKAY, 01 ERROR
hrdata  out  32  registered read data to master
valid  out  1  one-cycle pulse: mapped transfer accepted
sel  out  3  registered one-hot region select
haddr1, haddr2  out  32 each  address pipeline stages 1 and 2
hwdata1, hwdata2  out  32 each  write-data pipeline stages 1 and 2
hwrite_reg, hwrite_reg1  out  1 each  direction pipeline stages 1 and 2

Behaviour:
- Reset (async, any state):
  - State = IDLE.
  - hr_readyout = 1, hresp = 00.
  - valid = 0, sel = 000.
  - All data, address and pipeline registers = 0.
- Decode (combinational):
  - Region i (i = 0..2) hits when haddr[31:REGION_BITS] == BASE_ADDR[31:REGION_BITS] + i.
  - mapped = any hit; dsel = one-hot(i), otherwise 000.
- Sampling:
  - An address phase is sampled only on a rising edge where hr_readyout=1, hreadyin=1 and htrans[1]=1.
  - htrans IDLE or BUSY gives an OKAY response, with no state change and no valid pulse.
- Pipeline:
  - Advances on every edge with hr_readyout=1.
  - haddr1<=haddr, haddr2<=haddr1; hwdata1<=hwdata, hwdata2<=hwdata1; hwrite_reg<=hwrite, hwrite_reg1<=hwrite_reg.
  - Holds while hr_readyout=0.
- FSM states: IDLE, WAIT, ERR1, ERR2.
  - IDLE, sampled and mapped: next edge gives valid=1 (one cycle), sel<=dsel, hr_readyout<=0, state WAIT; the captured direction is stored.
  - IDLE, sampled and unmapped: next edge gives hr_readyout<=0, hresp<=01, sel<=000, state ERR1; no valid.
  - WAIT: hr_readyout stays 0, valid=0. On an edge with apb_done=1: hr_readyout<=1, hresp<=00, and hrdata<=prdata if the stored direction is read (hrdata unchanged on write); state IDLE.
  - ERR1: hr_readyout<=1, hresp stays 01, state ERR2.
  - ERR2: hresp<=00, state IDLE. Any address phase sampled in ERR2 is treated as cancelled (ignored).
- Latency:
  - Minimum mapped transfer: hr_readyout low for exactly one cycle when apb_done arrives on the first WAIT edge.
  - Back-to-back: a new address phase is sampled on the same edge hr_readyout is seen high, so there are no idle cycles between transfers.
- Corner cases:
  - apb_done outside WAIT is ignored.
  - Reset asserted mid-WAIT or mid-ERR aborts immediately; hrdata is cleared.
  - hreadyin=0 suppresses sampling regardless of htrans.

Optional Feature:
- Macro: AHB_SLAVE_TIMEOUT_EN.
- Defined:
  - An 8-bit counter clears on WAIT entry and increments each WAIT cycle without apb_done.
  - When the count reaches TIMEOUT_CYCLES-1 with no apb_done, the next edge gives hr_readyout<=0, hresp<=01, state ERR1, completing a standard two-cycle ERROR.
  - apb_done on the terminal edge wins: the transfer completes OKAY.
- Undefined: no counter; WAIT holds indefinitely until apb_done.

Test Plan:
- Reset mid-WAIT (hreset=1 three cycles after a transfer starts) -> hr_readyout=1, hresp=00, valid=0, sel=000, hrdata=0 immediately, without waiting for a clock edge.
- Single write: haddr=0x8400_0000, hwrite=1, htrans=2, then hwdata=0x29 -> valid pulse, sel=010, hwrite_reg=1, hwdata1=0x29; hr_readyout=0 until apb_done, then 1.
- Single read: haddr=0x8800_0010, prdata=0xDEAD_BEEF, apb_done 3 cycles after valid -> hr_readyout low 3 cycles, then hrdata=0xDEAD_BEEF, hresp=00, sel=100.
- Unmapped: haddr=0x9000_0000, htrans=2 -> ERR1 cycle (hr_readyout=0, hresp=01), then ERR2 (hr_readyout=1, hresp=01), then hresp=00; valid never asserted.
- INCR4 write: 0x8000_0000..0x8000_0003 (NONSEQ then 3×SEQ), apb_done one cycle after each valid -> four valid pulses, sel=001; haddr2 sequence 0..3 one stage behind haddr1.
- With AHB_SLAVE_TIMEOUT_EN: mapped read and no apb_done for 16 cycles -> two-cycle ERROR. Without the macro -> hr_readyout stays 0 for at least 32 cycles.

Source files
------------

// File: rtl/ahb_slave_if.sv
// ahb_slave_if: AHB-side slave interface of the AHB-to-APB bridge.
// Decodes three peripheral regions and holds HREADY low until the APB side
// reports completion. An unmapped address gets a two-cycle ERROR response.
// Address, write data and direction are pipelined for the APB controller.
// Optional feature (macro AHB_SLAVE_TIMEOUT_EN): if apb_done never arrives,
// a WAIT timeout ends the transfer with an ERROR response.
module ahb_slave_if #(
  parameter logic [31:0] BASE_ADDR      = 32'h8000_0000,
  parameter int          REGION_BITS    = 26,
  parameter int          TIMEOUT_CYCLES = 16
) (
  input  logic        hclk,
  input  logic        hreset,
  input  logic        hwrite,
  input  logic        hreadyin,
  input  logic [1:0]  htrans,
  input  logic [31:0] haddr,
  input  logic [31:0] hwdata,
  input  logic [31:0] prdata,
  input  logic        apb_done,
  output logic        hr_readyout,
  output logic [1:0]  hresp,
  output logic [31:0] hrdata,
  output logic        valid,
  output logic [2:0]  sel,
  output logic [31:0] haddr1,
  output logic [31:0] haddr2,
  output logic [31:0] hwdata1,
  output logic [31:0] hwdata2,
  output logic        hwrite_reg,
  output logic        hwrite_reg1
);

  localparam int TW = 32 - REGION_BITS;
  localparam logic [1:0] RESP_OKAY  = 2'b00;
  localparam logic [1:0] RESP_ERROR = 2'b01;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ERR1, ST_ERR2} state_t;

  state_t      r_state, w_state_next;
  logic        r_ready, w_ready_next;
  logic [1:0]  r_hresp, w_hresp_next;
  logic [31:0] r_hrdata, w_hrdata_next;
  logic        r_valid, w_valid_next;
  logic [2:0]  r_sel, w_sel_next;
  logic        r_dir, w_dir_next;
  logic [31:0] r_haddr1, r_haddr2, r_hwdata1, r_hwdata2;
  logic        r_hwrite1, r_hwrite2;

  logic [2:0]  w_hit;
  logic        w_mapped;
  logic        w_sample;

  // Region decode: region gi is the gi-th region-sized window above BASE_ADDR
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_region
      localparam logic [TW-1:0] REGION_TAG = TW'(BASE_ADDR[31:REGION_BITS] + gi);
      assign w_hit[gi] = (haddr[31:REGION_BITS] == REGION_TAG);
    end
  endgenerate

  assign w_mapped = |w_hit;
  // NONSEQ/SEQ with both ready signals high starts a transfer
  assign w_sample = r_ready & hreadyin & htrans[1];

`ifdef AHB_SLAVE_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] r_cnt, w_cnt_next;

  // Timeout counter register
  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) r_cnt <= '0;
    else        r_cnt <= w_cnt_next;
  end
`else
  // htrans[0] (BUSY vs IDLE, SEQ vs NONSEQ) does not change behaviour
  logic w_unused;
  assign w_unused = htrans[0] ^ (TIMEOUT_CYCLES == 0);
`endif

  // State and registered response outputs
  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      r_state  <= ST_IDLE;
      r_ready  <= 1'b1;
      r_hresp  <= RESP_OKAY;
      r_hrdata <= '0;
      r_valid  <= 1'b0;
      r_sel    <= '0;
      r_dir    <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_ready  <= w_ready_next;
      r_hresp  <= w_hresp_next;
      r_hrdata <= w_hrdata_next;
      r_valid  <= w_valid_next;
      r_sel    <= w_sel_next;
      r_dir    <= w_dir_next;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    w_state_next  = r_state;
    w_ready_next  = r_ready;
    w_hresp_next  = r_hresp;
    w_hrdata_next = r_hrdata;
    w_valid_next  = 1'b0;
    w_sel_next    = r_sel;
    w_dir_next    = r_dir;
`ifdef AHB_SLAVE_TIMEOUT_EN
    w_cnt_next    = r_cnt;
`endif
    case (r_state)
      ST_IDLE: begin
        w_ready_next = 1'b1;
        w_hresp_next = RESP_OKAY;
        if (w_sample) begin
          w_ready_next = 1'b0;
          if (w_mapped) begin
            w_valid_next = 1'b1;
            w_sel_next   = w_hit;
            w_dir_next   = hwrite;
            w_state_next = ST_WAIT;
`ifdef AHB_SLAVE_TIMEOUT_EN
            w_cnt_next   = '0;
`endif
          end else begin
            w_hresp_next = RESP_ERROR;
            w_sel_next   = '0;
            w_state_next = ST_ERR1;
          end
        end
      end
      ST_WAIT: begin
        w_ready_next = 1'b0;
        if (apb_done) begin
          w_ready_next = 1'b1;
          w_hresp_next = RESP_OKAY;
          if (!r_dir) w_hrdata_next = prdata;
          w_state_next = ST_IDLE;
        end
`ifdef AHB_SLAVE_TIMEOUT_EN
        else if (r_cnt == TIMEOUT_LAST) begin
          w_hresp_next = RESP_ERROR;
          w_state_next = ST_ERR1;
        end else begin
          w_cnt_next = r_cnt + 8'd1;
        end
`endif
      end
      ST_ERR1: begin
        w_ready_next = 1'b1;
        w_hresp_next = RESP_ERROR;
        w_state_next = ST_ERR2;
      end
      ST_ERR2: begin
        // Any address phase presented here is dropped as cancelled
        w_ready_next = 1'b1;
        w_hresp_next = RESP_OKAY;
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // Address/data/direction pipeline, frozen while the master is stalled
  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      r_haddr1  <= '0;
      r_haddr2  <= '0;
      r_hwdata1 <= '0;
      r_hwdata2 <= '0;
      r_hwrite1 <= 1'b0;
      r_hwrite2 <= 1'b0;
    end else if (r_ready) begin
      r_haddr1  <= haddr;
      r_haddr2  <= r_haddr1;
      r_hwdata1 <= hwdata;
      r_hwdata2 <= r_hwdata1;
      r_hwrite1 <= hwrite;
      r_hwrite2 <= r_hwrite1;
    end
  end

  assign hr_readyout = r_ready;
  assign hresp       = r_hresp;
  assign hrdata      = r_hrdata;
  assign valid       = r_valid;
  assign sel         = r_sel;
  assign haddr1      = r_haddr1;
  assign haddr2      = r_haddr2;
  assign hwdata1     = r_hwdata1;
  assign hwdata2     = r_hwdata2;
  assign hwrite_reg  = r_hwrite1;
  assign hwrite_reg1 = r_hwrite2;

endmodule

// File: tb/tb_ahb_slave_if.sv
// Directed testbench for ahb_slave_if.
// Inputs change 1 ns after a rising edge; outputs are checked at that point.
module tb_ahb_slave_if;

  logic        hclk = 1'b0;
  logic        hreset;
  logic        hwrite;
  logic        hreadyin;
  logic [1:0]  htrans;
  logic [31:0] haddr;
  logic [31:0] hwdata;
  logic [31:0] prdata;
  logic        apb_done;
  logic        hr_readyout;
  logic [1:0]  hresp;
  logic [31:0] hrdata;
  logic        valid;
  logic [2:0]  sel;
  logic [31:0] haddr1, haddr2, hwdata1, hwdata2;
  logic        hwrite_reg, hwrite_reg1;

  int n_checks = 0;
  int n_fail   = 0;
  int n_valid  = 0;
  int n_high   = 0;

  ahb_slave_if dut (
    .hclk(hclk), .hreset(hreset), .hwrite(hwrite), .hreadyin(hreadyin),
    .htrans(htrans), .haddr(haddr), .hwdata(hwdata), .prdata(prdata),
    .apb_done(apb_done), .hr_readyout(hr_readyout), .hresp(hresp),
    .hrdata(hrdata), .valid(valid), .sel(sel), .haddr1(haddr1),
    .haddr2(haddr2), .hwdata1(hwdata1), .hwdata2(hwdata2),
    .hwrite_reg(hwrite_reg), .hwrite_reg1(hwrite_reg1)
  );

  always #5 hclk = ~hclk;

  task automatic tick();
    @(posedge hclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    hreset = 1'b1; hwrite = 1'b0; hreadyin = 1'b1; htrans = 2'd0;
    haddr = '0; hwdata = '0; prdata = '0; apb_done = 1'b0;

    // Reset state
    tick(); tick();
    chk("rst_ready", 32'(hr_readyout), 32'd1);
    chk("rst_hresp", 32'(hresp), 32'd0);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_sel", 32'(sel), 32'd0);
    chk("rst_hrdata", hrdata, 32'd0);
    hreset = 1'b0;
    $display("reset released");

    // Single write to region 1
    haddr = 32'h8400_0000; hwrite = 1'b1; htrans = 2'd2; prdata = 32'h5555_5555;
    tick();
    htrans = 2'd0; hwdata = 32'h29;
    chk("wr_valid", 32'(valid), 32'd1);
    chk("wr_sel", 32'(sel), 32'b010);
    chk("wr_ready_lo", 32'(hr_readyout), 32'd0);
    chk("wr_hwrite_reg", 32'(hwrite_reg), 32'd1);
    chk("wr_haddr1", haddr1, 32'h8400_0000);
    tick();
    chk("wr_wait_ready", 32'(hr_readyout), 32'd0);
    chk("wr_valid_pulse", 32'(valid), 32'd0);
    apb_done = 1'b1;
    tick();
    apb_done = 1'b0;
    chk("wr_done_ready", 32'(hr_readyout), 32'd1);
    chk("wr_done_hresp", 32'(hresp), 32'd0);
    chk("wr_hrdata_kept", hrdata, 32'd0);
    tick();
    chk("wr_hwdata1", hwdata1, 32'h29);
    chk("wr_haddr2", haddr2, 32'h8400_0000);
    $display("single write done: hwdata1=%h", hwdata1);

    // Single read from region 2, apb_done three cycles after valid
    haddr = 32'h8800_0010; hwrite = 1'b0; htrans = 2'd2; prdata = 32'hDEAD_BEEF;
    tick();
    htrans = 2'd0;
    chk("rd_valid", 32'(valid), 32'd1);
    chk("rd_sel", 32'(sel), 32'b100);
    chk("rd_ready1", 32'(hr_readyout), 32'd0);
    tick();
    chk("rd_ready2", 32'(hr_readyout), 32'd0);
    tick();
    chk("rd_ready3", 32'(hr_readyout), 32'd0);
    apb_done = 1'b1;
    tick();
    chk("rd_ready_hi", 32'(hr_readyout), 32'd1);
    chk("rd_hrdata", hrdata, 32'hDEAD_BEEF);
    chk("rd_hresp", 32'(hresp), 32'd0);
    chk("rd_sel_hold", 32'(sel), 32'b100);
    // apb_done while idle must be ignored
    prdata = 32'h1111_2222;
    tick();
    apb_done = 1'b0;
    chk("idle_done_ready", 32'(hr_readyout), 32'd1);
    chk("idle_done_hrdata", hrdata, 32'hDEAD_BEEF);
    $display("single read done: hrdata=%h", hrdata);

    // Reset asserted three cycles into a WAIT
    haddr = 32'h8000_0008; htrans = 2'd2;
    tick();
    htrans = 2'd0;
    tick(); tick();
    chk("rstw_pre_ready", 32'(hr_readyout), 32'd0);
    hreset = 1'b1;
    #1;
    chk("rstw_ready", 32'(hr_readyout), 32'd1);
    chk("rstw_hresp", 32'(hresp), 32'd0);
    chk("rstw_valid", 32'(valid), 32'd0);
    chk("rstw_sel", 32'(sel), 32'd0);
    chk("rstw_hrdata", hrdata, 32'd0);
    chk("rstw_haddr1", haddr1, 32'd0);
    tick();
    hreset = 1'b0;
    $display("reset mid-wait done");

    // Unmapped address; a mapped phase offered during ERR2 is dropped
    haddr = 32'h9000_0000; htrans = 2'd2;
    tick();
    chk("err1_ready", 32'(hr_readyout), 32'd0);
    chk("err1_hresp", 32'(hresp), 32'd1);
    chk("err1_valid", 32'(valid), 32'd0);
    haddr = 32'h8000_0000;
    tick();
    chk("err2_ready", 32'(hr_readyout), 32'd1);
    chk("err2_hresp", 32'(hresp), 32'd1);
    chk("err2_valid", 32'(valid), 32'd0);
    tick();
    htrans = 2'd0;
    chk("errend_hresp", 32'(hresp), 32'd0);
    chk("errend_ready", 32'(hr_readyout), 32'd1);
    chk("errend_valid", 32'(valid), 32'd0);
    chk("errend_sel", 32'(sel), 32'd0);
    $display("unmapped transfer done");

    // BUSY and hreadyin=0 must not start a transfer
    htrans = 2'd1;
    tick();
    chk("busy_valid", 32'(valid), 32'd0);
    chk("busy_ready", 32'(hr_readyout), 32'd1);
    htrans = 2'd2; hreadyin = 1'b0;
    tick();
    chk("nordy_valid", 32'(valid), 32'd0);
    chk("nordy_ready", 32'(hr_readyout), 32'd1);
    hreadyin = 1'b1;

    // INCR4 write to region 0, apb_done one cycle after each valid
    hwrite = 1'b1;
    for (int k = 0; k < 4; k++) begin
      haddr  = 32'h8000_0000 + 32'(k);
      htrans = (k == 0) ? 2'd2 : 2'd3;
      hwdata = 32'h100 + 32'(k);
      tick();
      if (valid === 1'b1) n_valid++;
      chk($sformatf("incr_valid%0d", k), 32'(valid), 32'd1);
      chk($sformatf("incr_sel%0d", k), 32'(sel), 32'b001);
      chk($sformatf("incr_haddr1_%0d", k), haddr1, 32'h8000_0000 + 32'(k));
      if (k > 0) chk($sformatf("incr_haddr2_%0d", k), haddr2, 32'h8000_0000 + 32'(k - 1));
      tick();
      if (valid === 1'b1) n_valid++;
      apb_done = 1'b1;
      tick();
      apb_done = 1'b0;
      chk($sformatf("incr_ready%0d", k), 32'(hr_readyout), 32'd1);
      $display("incr4 beat %0d: haddr1=%h haddr2=%h", k, haddr1, haddr2);
    end
    htrans = 2'd0;
    chk("incr_valid_count", 32'(n_valid), 32'd4);

    // Mapped read with no apb_done
    haddr = 32'h8000_0004; hwrite = 1'b0; htrans = 2'd2;
    tick();
    htrans = 2'd0;
    chk("to_valid", 32'(valid), 32'd1);
`ifdef AHB_SLAVE_TIMEOUT_EN
    repeat (15) tick();
    chk("to_wait_ready", 32'(hr_readyout), 32'd0);
    chk("to_wait_hresp", 32'(hresp), 32'd0);
    tick();
    chk("to_err1_ready", 32'(hr_readyout), 32'd0);
    chk("to_err1_hresp", 32'(hresp), 32'd1);
    tick();
    chk("to_err2_ready", 32'(hr_readyout), 32'd1);
    chk("to_err2_hresp", 32'(hresp), 32'd1);
    tick();
    chk("to_end_hresp", 32'(hresp), 32'd0);
`else
    for (int i = 0; i < 32; i++) begin
      tick();
      if (hr_readyout !== 1'b0) n_high++;
    end
    chk("nto_ready_high_cycles", 32'(n_high), 32'd0);
    chk("nto_hresp", 32'(hresp), 32'd0);
`endif
    $display("no-apb_done transfer done");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
